// File: rtl/key_debounce_9_if.sv
// key_debounce_9_if: pin-side bundle for the 9-key debounce front end.
// master drives raw keys; slave (the debouncer) drives clean levels/events.
interface key_debounce_9_if;
  logic [8:0] key_n;
  logic [8:0] key_db_n;
  logic [8:0] press_pulse;
  logic       any_pressed;

  modport master (
    output key_n,
    input  key_db_n,
    input  press_pulse,
    input  any_pressed
  );

  modport slave (
    input  key_n,
    output key_db_n,
    output press_pulse,
    output any_pressed
  );
endinterface

// File: rtl/key_debounce_9.sv
// key_debounce_9: 2-flop sync + per-key debounce + press strobe.
// Optional auto-repeat of press_pulse under `define KEY_AUTOREPEAT_EN.
module key_debounce_9 #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input logic       clk,
  input logic       rst_n,
  key_debounce_9_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

  logic [8:0]    s1;
  logic [8:0]    s2;
  logic [8:0]    stable;
  logic [8:0]    pulse;
  logic [8:0]    acc;
  logic [8:0]    press;
  logic [8:0]    event_hit;
  logic [DW-1:0] cnt [9];

  // Bring the asynchronous pins into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 9'h1FF;
      s2 <= 9'h1FF;
    end else begin
      s1 <= bus.key_n;
      s2 <= s1;
    end
  end

  // A key flips its accepted level on the last cycle of a full run.
  always_comb begin
    acc = '0;
    for (int i = 0; i < 9; i++) begin
      acc[i] = (s2[i] != stable[i]) && (cnt[i] == DMAX);
    end
    press = acc & stable;
  end

  // Per-key run counter; any return to the stable level restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 9'h1FF;
      for (int i = 0; i < 9; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (acc[i]) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RMAX = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rpt [9];
  logic [8:0]    rel;
  logic [8:0]    rpt_hit;

  // Repeat fires only while held and not on the edge of release.
  always_comb begin
    rel     = acc & ~stable;
    rpt_hit = '0;
    for (int i = 0; i < 9; i++) begin
      rpt_hit[i] = !stable[i] && !rel[i] && (rpt[i] == RMAX);
    end
    event_hit = press | rpt_hit;
  end

  // Hold-time counter per key, reloading on each repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        rpt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (stable[i] || press[i]) begin
          rpt[i] <= '0;
        end else if (rpt[i] == RMAX) begin
          rpt[i] <= '0;
        end else begin
          rpt[i] <= rpt[i] + 1'b1;
        end
      end
    end
  end
`else
  // Exactly one strobe per accepted press.
  always_comb begin
    event_hit = press;
  end
`endif

  // Strobe lands in the same cycle the new level appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse <= '0;
    end else begin
      pulse <= event_hit;
    end
  end

  assign bus.key_db_n    = stable;
  assign bus.press_pulse = pulse;
  assign bus.any_pressed = ~&stable;

endmodule
